// File: rtl/pong_renderer.sv
// Pong game core and pixel renderer. Game state advances once per frame on
// frame_tick (start of vertical blanking); the pixel colour is produced one
// cycle after the matching hpos/vpos/display_on sample.
module pong_renderer #(
   parameter int BALL_SIZE    = 8,
   parameter int PADDLE_H     = 64,
   parameter int PADDLE_STEP  = 4,
   parameter int BALL_SPEED   = 2,
   parameter int SERVE_FRAMES = 60
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  hpos,
   input  logic [9:0]  vpos,
   input  logic        display_on,
   input  logic        btn_l_up,
   input  logic        btn_l_dn,
   input  logic        btn_r_up,
   input  logic        btn_r_dn,
   output logic [11:0] rgb,
   output logic [3:0]  score_l,
   output logic [3:0]  score_r,
   output logic        frame_tick
);

   localparam logic [1:0] ST_SERVE  = 2'd0;
   localparam logic [1:0] ST_PLAY   = 2'd1;
   localparam logic [1:0] ST_SCORED = 2'd2;
   localparam logic [1:0] ST_OVER   = 2'd3;

   localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES);

   // Signed 11-bit game arithmetic so off-screen "next" positions stay representable.
   localparam logic signed [10:0] BSZ     = 11'(BALL_SIZE);
   localparam logic signed [10:0] SPD     = 11'(BALL_SPEED);
   localparam logic signed [10:0] STEP    = 11'(PADDLE_STEP);
   localparam logic signed [10:0] PH      = 11'(PADDLE_H);
   localparam logic signed [10:0] PAD_MAX = 11'(480 - PADDLE_H);
   localparam logic [10:0] BSZ_U    = 11'(BALL_SIZE);
   localparam logic [10:0] PH_U     = 11'(PADDLE_H);
   localparam logic [10:0] SERVE_X  = 11'd316;
   localparam logic [10:0] SERVE_Y  = 11'd236;
   localparam logic [10:0] PAD_INIT = 11'd208;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] serve_cnt_q, serve_cnt_d;
   logic [10:0]      ball_x_q, ball_x_d, ball_y_q, ball_y_d;
   logic [10:0]      pad_l_q, pad_l_d, pad_r_q, pad_r_d;
   logic             dx_q, dx_d, dy_q, dy_d;            // 1 = right / down
   logic             serve_dir_q, serve_dir_d;          // 1 = right
   logic [3:0]       score_l_q, score_l_d, score_r_q, score_r_d;
   logic             frame_tick_q, frame_tick_d;
   logic [11:0]      rgb_q, rgb_d;

   logic signed [10:0] bx, by, nx, ny;
   logic               ovl_l, ovl_r, hit_l, hit_r;
   logic [10:0]        hp, vp;
   logic               in_ball, in_pad, in_line;

   // Paddle move: up/down by STEP, no move when both pressed, clamped to screen.
   function automatic logic [10:0] pad_next(input logic [10:0] y, input logic up,
                                            input logic dn);
      logic signed [10:0] t;
      t = signed'(y);
      if (up && !dn)
         t = t - STEP;
      else if (dn && !up)
         t = t + STEP;
      if (t < 11'sd0)
         t = 11'sd0;
      else if (t > PAD_MAX)
         t = PAD_MAX;
      return unsigned'(t);
   endfunction

   // Per-frame game update: paddles, serve timer, ball motion, scoring.
   always_comb begin
      state_d     = state_q;
      serve_cnt_d = serve_cnt_q;
      ball_x_d    = ball_x_q;
      ball_y_d    = ball_y_q;
      pad_l_d     = pad_l_q;
      pad_r_d     = pad_r_q;
      dx_d        = dx_q;
      dy_d        = dy_q;
      serve_dir_d = serve_dir_q;
      score_l_d   = score_l_q;
      score_r_d   = score_r_q;
      frame_tick_d = (hpos == 10'd0) && (vpos == 10'd480);

      bx = signed'(ball_x_q);
      by = signed'(ball_y_q);
      nx = dx_q ? bx + SPD : bx - SPD;
      ny = dy_q ? by + SPD : by - SPD;
      // Overlap uses the paddle position from before this frame's move.
      ovl_l = (by + BSZ > signed'(pad_l_q)) && (by < signed'(pad_l_q) + PH);
      ovl_r = (by + BSZ > signed'(pad_r_q)) && (by < signed'(pad_r_q) + PH);
      hit_l = !dx_q && (nx <= 11'sd24) && ovl_l;
      hit_r = dx_q && (nx + BSZ >= 11'sd616) && ovl_r;

      if (frame_tick_q) begin
         pad_l_d = pad_next(pad_l_q, btn_l_up, btn_l_dn);
         pad_r_d = pad_next(pad_r_q, btn_r_up, btn_r_dn);
         case (state_q)
            ST_SERVE: begin
               ball_x_d = SERVE_X;
               ball_y_d = SERVE_Y;
               if (serve_cnt_q + 1'b1 == CNT_LAST) begin
                  serve_cnt_d = '0;
                  state_d     = ST_PLAY;
               end else begin
                  serve_cnt_d = serve_cnt_q + 1'b1;
               end
            end
            ST_PLAY: begin
               // Vertical wall bounce is independent of the paddle/edge logic.
               if (ny < 11'sd0) begin
                  ball_y_d = 11'd0;
                  dy_d     = 1'b1;
               end else if (ny + BSZ > 11'sd480) begin
                  ball_y_d = unsigned'(11'sd480 - BSZ);
                  dy_d     = 1'b0;
               end else begin
                  ball_y_d = unsigned'(ny);
               end
               if (hit_l) begin
                  ball_x_d = 11'd24;
                  dx_d     = 1'b1;
               end else if (hit_r) begin
                  ball_x_d = unsigned'(11'sd616 - BSZ);
                  dx_d     = 1'b0;
               end else if (!dx_q && (nx <= 11'sd0)) begin
                  ball_x_d    = 11'd0;
                  score_r_d   = score_r_q + 4'd1;
                  serve_dir_d = 1'b0;
                  state_d     = ST_SCORED;
               end else if (dx_q && (nx + BSZ >= 11'sd640)) begin
                  ball_x_d    = unsigned'(11'sd640 - BSZ);
                  score_l_d   = score_l_q + 4'd1;
                  serve_dir_d = 1'b1;
                  state_d     = ST_SCORED;
               end else begin
                  ball_x_d = unsigned'(nx);
               end
            end
            ST_SCORED: begin
               ball_x_d = SERVE_X;
               ball_y_d = SERVE_Y;
               dx_d     = serve_dir_q;
               dy_d     = 1'b1;
               state_d  = ((score_l_q == 4'd9) || (score_r_q == 4'd9)) ? ST_OVER : ST_SERVE;
            end
            default: ;
         endcase
      end
   end

   // Pixel colour by priority: ball, paddles, dashed centre line, background.
   always_comb begin
      hp      = {1'b0, hpos};
      vp      = {1'b0, vpos};
      in_ball = (state_q != ST_OVER) &&
                (hp >= ball_x_q) && (hp < ball_x_q + BSZ_U) &&
                (vp >= ball_y_q) && (vp < ball_y_q + BSZ_U);
      in_pad  = ((hp >= 11'd16) && (hp <= 11'd23) && (vp >= pad_l_q) && (vp < pad_l_q + PH_U)) ||
                ((hp >= 11'd616) && (hp <= 11'd623) && (vp >= pad_r_q) && (vp < pad_r_q + PH_U));
      in_line = ((hpos == 10'd319) || (hpos == 10'd320)) && !vpos[3];
      rgb_d   = 12'h000;
      if (display_on) begin
         if (in_ball)
            rgb_d = 12'hFFF;
         else if (in_pad)
            rgb_d = 12'h0F0;
         else if (in_line)
            rgb_d = 12'h888;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_SERVE;
         serve_cnt_q  <= '0;
         ball_x_q     <= SERVE_X;
         ball_y_q     <= SERVE_Y;
         pad_l_q      <= PAD_INIT;
         pad_r_q      <= PAD_INIT;
         dx_q         <= 1'b0;
         dy_q         <= 1'b1;
         serve_dir_q  <= 1'b0;
         score_l_q    <= 4'd0;
         score_r_q    <= 4'd0;
         frame_tick_q <= 1'b0;
         rgb_q        <= 12'h000;
      end else begin
         state_q      <= state_d;
         serve_cnt_q  <= serve_cnt_d;
         ball_x_q     <= ball_x_d;
         ball_y_q     <= ball_y_d;
         pad_l_q      <= pad_l_d;
         pad_r_q      <= pad_r_d;
         dx_q         <= dx_d;
         dy_q         <= dy_d;
         serve_dir_q  <= serve_dir_d;
         score_l_q    <= score_l_d;
         score_r_q    <= score_r_d;
         frame_tick_q <= frame_tick_d;
         rgb_q        <= rgb_d;
      end
   end

   assign rgb        = rgb_q;
   assign score_l    = score_l_q;
   assign score_r    = score_r_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_pong_renderer.sv
// Directed bench for pong_renderer: drives hpos/vpos directly, issuing one
// frame tick per call and probing individual pixels in between.
module tb_pong_renderer;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  hpos, vpos;
   logic        display_on;
   logic        btn_l_up, btn_l_dn, btn_r_up, btn_r_dn;
   logic [11:0] rgb;
   logic [3:0]  score_l, score_r;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;
   int tick_no = 0;
   int ft_bad = 0;

   typedef struct {
      int          x;
      int          y;
      logic        de;
      logic [11:0] exp;
   } px_vec_t;

   px_vec_t vecs [22];

   pong_renderer dut (
      .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
      .btn_l_up(btn_l_up), .btn_l_dn(btn_l_dn), .btn_r_up(btn_r_up), .btn_r_dn(btn_r_dn),
      .rgb(rgb), .score_l(score_l), .score_r(score_r), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic probe(input int x, input int y, input logic de, output logic [11:0] c);
      hpos = 10'(x);
      vpos = 10'(y);
      display_on = de;
      @(posedge clk);
      #1;
      c = rgb;
   endtask

   task automatic chk_px(input string name, input int x, input int y, input logic [11:0] exp);
      logic [11:0] c;
      probe(x, y, 1'b1, c);
      chk($sformatf("%s(%0d,%0d)", name, x, y), c, exp);
   endtask

   // Ball top-left at (x,y): both corners white, pixel left and above not white.
   task automatic check_ball(input string name, input int x, input int y);
      logic [11:0] c;
      probe(x, y, 1'b1, c);
      chk({name, "_tl"}, c, 12'hFFF);
      probe(x + 7, y + 7, 1'b1, c);
      chk({name, "_br"}, c, 12'hFFF);
      probe(x - 1, y, 1'b1, c);
      chk({name, "_left_edge"}, (c != 12'hFFF), 1);
      probe(x, y - 1, 1'b1, c);
      chk({name, "_top_edge"}, (c != 12'hFFF), 1);
   endtask

   task automatic tick(input logic lu, input logic ld, input logic ru, input logic rd);
      btn_l_up = lu; btn_l_dn = ld; btn_r_up = ru; btn_r_dn = rd;
      hpos = 10'd0; vpos = 10'd480; display_on = 1'b0;
      @(posedge clk);
      #1;
      if (frame_tick !== 1'b1) ft_bad++;
      hpos = 10'd799; vpos = 10'd524;
      @(posedge clk);
      #1;
      if (frame_tick !== 1'b0) ft_bad++;
      tick_no++;
   endtask

   task automatic run_to(input int target, input logic lu, input logic ld,
                         input logic ru, input logic rd);
      while (tick_no < target) tick(lu, ld, ru, rd);
   endtask

   initial begin
      logic [11:0] c;
      vecs[0]  = '{316, 236, 1'b1, 12'hFFF};
      vecs[1]  = '{323, 243, 1'b1, 12'hFFF};
      vecs[2]  = '{324, 236, 1'b1, 12'h000};
      vecs[3]  = '{315, 240, 1'b1, 12'h000};
      vecs[4]  = '{319, 240, 1'b1, 12'hFFF};
      vecs[5]  = '{319, 244, 1'b1, 12'h888};
      vecs[6]  = '{320, 0,   1'b1, 12'h888};
      vecs[7]  = '{320, 8,   1'b1, 12'h000};
      vecs[8]  = '{321, 0,   1'b1, 12'h000};
      vecs[9]  = '{318, 0,   1'b1, 12'h000};
      vecs[10] = '{16,  208, 1'b1, 12'h0F0};
      vecs[11] = '{23,  271, 1'b1, 12'h0F0};
      vecs[12] = '{24,  208, 1'b1, 12'h000};
      vecs[13] = '{15,  208, 1'b1, 12'h000};
      vecs[14] = '{16,  207, 1'b1, 12'h000};
      vecs[15] = '{16,  272, 1'b1, 12'h000};
      vecs[16] = '{616, 208, 1'b1, 12'h0F0};
      vecs[17] = '{623, 271, 1'b1, 12'h0F0};
      vecs[18] = '{624, 240, 1'b1, 12'h000};
      vecs[19] = '{615, 240, 1'b1, 12'h000};
      vecs[20] = '{316, 236, 1'b0, 12'h000};
      vecs[21] = '{16,  208, 1'b0, 12'h000};

      // Reset state, with the tick condition present on the inputs
      reset = 1'b1;
      btn_l_up = 0; btn_l_dn = 0; btn_r_up = 0; btn_r_dn = 0;
      hpos = 10'd0; vpos = 10'd480; display_on = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rgb", rgb, 12'h000);
      chk("reset_score_l", score_l, 0);
      chk("reset_score_r", score_r, 0);
      chk("reset_frame_tick", frame_tick, 0);
      hpos = 10'd799; vpos = 10'd524;
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Near-miss tick positions must not pulse
      hpos = 10'd0; vpos = 10'd479; display_on = 1'b0;
      @(posedge clk); #1;
      chk("ft_vpos479", frame_tick, 0);
      hpos = 10'd1; vpos = 10'd480;
      @(posedge clk); #1;
      chk("ft_hpos1", frame_tick, 0);

      // Pixel table after reset
      for (int i = 0; i < 22; i++) begin
         probe(vecs[i].x, vecs[i].y, vecs[i].de, c);
         chk($sformatf("px_%0d(%0d,%0d)", i, vecs[i].x, vecs[i].y), c, vecs[i].exp);
      end

      // Serve hold; left paddle up, right paddle both buttons
      run_to(26, 1, 0, 1, 1);
      chk_px("padl_104_above", 16, 103, 12'h000);
      chk_px("padl_104_top", 16, 104, 12'h0F0);
      chk_px("padr_hold_above", 616, 207, 12'h000);
      chk_px("padr_hold_top", 616, 208, 12'h0F0);
      check_ball("serve_t26", 316, 236);
      run_to(51, 1, 0, 0, 0);
      chk_px("padl_4_above", 16, 3, 12'h000);
      chk_px("padl_4_top", 16, 4, 12'h0F0);
      run_to(59, 1, 0, 0, 0);
      chk_px("padl_0_top", 16, 0, 12'h0F0);
      chk_px("padl_0_below", 16, 64, 12'h000);
      run_to(60, 1, 1, 0, 0);
      chk_px("padl_both_top", 16, 0, 12'h0F0);
      chk_px("padl_both_below", 16, 64, 12'h000);
      check_ball("serve_t60", 316, 236);
      run_to(61, 0, 1, 0, 0);
      check_ball("first_move", 314, 238);
      chk_px("padl_down4", 16, 4, 12'h0F0);

      // Left paddle down to its bottom clamp
      run_to(164, 0, 1, 0, 0);
      chk_px("padl_416_above", 16, 415, 12'h000);
      chk_px("padl_416_top", 16, 416, 12'h0F0);
      run_to(178, 0, 1, 0, 0);
      check_ball("bottom_reach", 80, 472);
      chk_px("padl_clamp_above", 16, 415, 12'h000);
      chk_px("padl_clamp_bot", 16, 479, 12'h0F0);
      run_to(179, 0, 0, 0, 0);
      check_ball("bottom_bounce", 78, 472);
      run_to(180, 0, 0, 0, 0);
      check_ball("after_bounce", 76, 470);

      // Left paddle hit
      run_to(205, 0, 0, 0, 0);
      check_ball("pre_hit", 26, 420);
      run_to(206, 0, 0, 0, 0);
      check_ball("left_hit", 24, 418);
      run_to(207, 0, 0, 0, 0);
      check_ball("after_hit", 26, 416);

      // Top wall bounce then right miss
      run_to(416, 0, 0, 0, 0);
      check_ball("top_clamp", 444, 0);
      run_to(417, 0, 0, 0, 0);
      check_ball("top_bounce", 446, 2);
      run_to(509, 0, 0, 0, 0);
      check_ball("pre_rmiss", 630, 186);
      chk("score_l_pre_rmiss", score_l, 0);
      run_to(510, 0, 0, 0, 0);
      chk("score_l_rmiss", score_l, 1);
      chk("score_r_rmiss", score_r, 0);
      run_to(511, 0, 0, 0, 0);
      check_ball("reserve", 316, 236);
      chk("score_l_reserve", score_l, 1);

      // Repeated right misses up to game over
      run_to(728, 0, 0, 0, 0);
      chk("score_l_t728", score_l, 1);
      run_to(729, 0, 0, 0, 0);
      chk("score_l_t729", score_l, 2);
      run_to(2261, 0, 0, 0, 0);
      chk("score_l_8", score_l, 8);
      run_to(2262, 0, 0, 0, 0);
      chk("score_l_9", score_l, 9);
      run_to(2263, 0, 0, 0, 0);
      chk_px("over_ball_tl", 316, 236, 12'h000);
      chk_px("over_ball_br", 323, 243, 12'h000);
      chk_px("over_line", 319, 240, 12'h888);
      chk_px("over_padl", 16, 416, 12'h0F0);
      chk_px("over_padr", 616, 208, 12'h0F0);
      run_to(2264, 0, 0, 0, 1);
      chk_px("over_padr_moved_old", 616, 208, 12'h000);
      chk_px("over_padr_moved_new", 616, 212, 12'h0F0);
      run_to(2400, 0, 0, 0, 0);
      chk_px("over_persist_ball", 316, 236, 12'h000);
      chk("over_score_l", score_l, 9);
      chk("over_score_r", score_r, 0);

      // Asynchronous reset mid-game, then a left miss
      hpos = 10'd16; vpos = 10'd416; display_on = 1'b1;
      @(posedge clk);
      #2;
      chk("pre_areset_px", rgb, 12'h0F0);
      reset = 1'b1;
      #1;
      chk("areset_rgb", rgb, 12'h000);
      chk("areset_score_l", score_l, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick_no = 0;
      chk_px("areset_padl", 16, 208, 12'h0F0);
      chk_px("areset_padl_old", 16, 416, 12'h000);
      run_to(217, 0, 0, 0, 0);
      check_ball("pre_lmiss", 2, 396);
      chk("score_r_pre_lmiss", score_r, 0);
      run_to(218, 0, 0, 0, 0);
      chk("score_r_lmiss", score_r, 1);
      chk("score_l_lmiss", score_l, 0);
      run_to(219, 0, 0, 0, 0);
      check_ball("lmiss_reserve", 316, 236);
      chk("score_r_reserve", score_r, 1);

      chk("frame_tick_pulses", ft_bad, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
